// File: rtl/nf_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nf_mailbox_pkg
// Description : Shared helpers for the nf_mailbox block. Provides the FIFO
//               pointer-width helper. Each pointer holds an index plus one
//               extra wrap bit.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package nf_mailbox_pkg;

  // Width of a read/write pointer for a FIFO of 'depth' words.
  // The value is the index width plus the wrap bit.
  function automatic int nf_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nf_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Pointers carry a
//               wrap bit: the FIFO is empty when the pointers are equal, and
//               full when the indices match and the wrap bits differ.
// Ports       : clk, resetn (async active-low)
//               push/pdata  - write request and data (ignored when full)
//               pop         - read request (ignored when empty)
//               head        - word at the read index (raw, ungated)
//               empty/full  - status decoded from the registered pointers
//               level       - wr_ptr - rd_ptr
// Revision    : 1.0 - initial release
// ============================================================================
module nf_sync_fifo
  import nf_mailbox_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_PTR_W = nf_ptr_width(DEPTH);
  localparam int c_IDX_W = c_PTR_W - 1;

  logic [c_PTR_W-1:0] r_wr;
  logic [c_PTR_W-1:0] r_rd;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[c_IDX_W-1:0] == r_rd[c_IDX_W-1:0]) &&
                 (r_wr[c_PTR_W-1] != r_rd[c_PTR_W-1]);
  assign level = r_wr - r_rd;
  assign head  = r_mem[r_rd[c_IDX_W-1:0]];

  // Acceptance uses only the registered flags. A push to a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + c_PTR_W'(1);
      if (w_pop_ok)  r_rd <= r_rd + c_PTR_W'(1);
    end
  end

  // Storage needs no reset. Stale words are never visible because the
  // mailbox gates the head with the not-empty flag.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr[c_IDX_W-1:0]] <= pdata;
  end

endmodule
`default_nettype wire

// File: rtl/nf_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : nf_mailbox
// Description : Bidirectional message mailbox between side 1 and side 2.
//               Each direction has its own FIFO. The block adds
//               receive-valid, occupancy, full back-pressure (wait) and a
//               sticky overflow flag per side. Every output is decoded from
//               registered state only.
// Ports       : clk, resetn (async active-low)
//               we_x/data_x_in  - side x push into its outgoing FIFO
//               re_x            - side x pop from its incoming FIFO
//               data_x_out      - incoming head, zero when rx_valid_x=0
//               rx_valid_x      - incoming FIFO not empty
//               wait_x          - outgoing FIFO full
//               level_x         - words pending in incoming FIFO
//               ovf_x/clr_ovf_x - sticky dropped-push flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module nf_mailbox
  import nf_mailbox_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  // side 1
  input  logic                   we_1,
  input  logic [WIDTH-1:0]       data_1_in,
  input  logic                   re_1,
  output logic [WIDTH-1:0]       data_1_out,
  output logic                   rx_valid_1,
  output logic                   wait_1,
  output logic [$clog2(DEPTH):0] level_1,
  output logic                   ovf_1,
  input  logic                   clr_ovf_1,
  // side 2
  input  logic                   we_2,
  input  logic [WIDTH-1:0]       data_2_in,
  input  logic                   re_2,
  output logic [WIDTH-1:0]       data_2_out,
  output logic                   rx_valid_2,
  output logic                   wait_2,
  output logic [$clog2(DEPTH):0] level_2,
  output logic                   ovf_2,
  input  logic                   clr_ovf_2
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 1) begin : g_param_check
      $error("nf_mailbox: DEPTH must be a power of two >= 2 and WIDTH >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] w_head_12, w_head_21;
  logic             w_empty_12, w_empty_21;
  logic             w_full_12, w_full_21;
  logic             r_ovf_1, r_ovf_2;

  // FIFO 1->2: side 1 writes, side 2 reads.
  nf_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_12 (
    .clk    (clk),
    .resetn (resetn),
    .push   (we_1),
    .pdata  (data_1_in),
    .pop    (re_2),
    .head   (w_head_12),
    .empty  (w_empty_12),
    .full   (w_full_12),
    .level  (level_2)
  );

  // FIFO 2->1: side 2 writes, side 1 reads.
  nf_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_21 (
    .clk    (clk),
    .resetn (resetn),
    .push   (we_2),
    .pdata  (data_2_in),
    .pop    (re_1),
    .head   (w_head_21),
    .empty  (w_empty_21),
    .full   (w_full_21),
    .level  (level_1)
  );

  assign rx_valid_1 = !w_empty_21;
  assign rx_valid_2 = !w_empty_12;
  assign wait_1     = w_full_12;
  assign wait_2     = w_full_21;
  assign data_1_out = rx_valid_1 ? w_head_21 : '0;
  assign data_2_out = rx_valid_2 ? w_head_12 : '0;
  assign ovf_1      = r_ovf_1;
  assign ovf_2      = r_ovf_2;

  // A dropping push takes priority over a clear in the same cycle, so an
  // overflow is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf_1 <= 1'b0;
      r_ovf_2 <= 1'b0;
    end else begin
      if (we_1 && w_full_12)  r_ovf_1 <= 1'b1;
      else if (clr_ovf_1)     r_ovf_1 <= 1'b0;
      if (we_2 && w_full_21)  r_ovf_2 <= 1'b1;
      else if (clr_ovf_2)     r_ovf_2 <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nf_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_nf_mailbox
// Description : Self-checking bench for nf_mailbox (WIDTH=8, DEPTH=4).
//               A queue-based reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nf_mailbox;

  localparam int c_W = 8;
  localparam int c_D = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic           we_1, re_1, clr_ovf_1, we_2, re_2, clr_ovf_2;
  logic [c_W-1:0] data_1_in, data_2_in, data_1_out, data_2_out;
  logic           rx_valid_1, rx_valid_2, wait_1, wait_2, ovf_1, ovf_2;
  logic [2:0]     level_1, level_2;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per direction plus the sticky flags.
  logic [c_W-1:0] q12[$];
  logic [c_W-1:0] q21[$];
  bit             m_ovf1, m_ovf2;

  always #5 clk = ~clk;

  nf_mailbox #(.WIDTH(c_W), .DEPTH(c_D)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .we_1       (we_1),
    .data_1_in  (data_1_in),
    .re_1       (re_1),
    .data_1_out (data_1_out),
    .rx_valid_1 (rx_valid_1),
    .wait_1     (wait_1),
    .level_1    (level_1),
    .ovf_1      (ovf_1),
    .clr_ovf_1  (clr_ovf_1),
    .we_2       (we_2),
    .data_2_in  (data_2_in),
    .re_2       (re_2),
    .data_2_out (data_2_out),
    .rx_valid_2 (rx_valid_2),
    .wait_2     (wait_2),
    .level_2    (level_2),
    .ovf_2      (ovf_2),
    .clr_ovf_2  (clr_ovf_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_2_out"}, 32'(data_2_out), (q12.size() != 0) ? 32'(q12[0]) : 32'd0);
    chk({tag, ".rx_valid_2"}, 32'(rx_valid_2), 32'(q12.size() != 0));
    chk({tag, ".level_2"},    32'(level_2),    32'(q12.size()));
    chk({tag, ".wait_1"},     32'(wait_1),     32'(q12.size() == c_D));
    chk({tag, ".ovf_1"},      32'(ovf_1),      32'(m_ovf1));
    chk({tag, ".data_1_out"}, 32'(data_1_out), (q21.size() != 0) ? 32'(q21[0]) : 32'd0);
    chk({tag, ".rx_valid_1"}, 32'(rx_valid_1), 32'(q21.size() != 0));
    chk({tag, ".level_1"},    32'(level_1),    32'(q21.size()));
    chk({tag, ".wait_2"},     32'(wait_2),     32'(q21.size() == c_D));
    chk({tag, ".ovf_2"},      32'(ovf_2),      32'(m_ovf2));
  endtask

  // One clock: apply inputs, update the model at the edge, check 1 ns later.
  task automatic cyc(input string tag,
                     input bit w1, input logic [7:0] d1, input bit r1, input bit c1,
                     input bit w2, input logic [7:0] d2, input bit r2, input bit c2);
    bit f12, f21, e12, e21;
    we_1 = w1; data_1_in = d1; re_1 = r1; clr_ovf_1 = c1;
    we_2 = w2; data_2_in = d2; re_2 = r2; clr_ovf_2 = c2;
    @(posedge clk);
    f12 = (q12.size() == c_D); e12 = (q12.size() == 0);
    f21 = (q21.size() == c_D); e21 = (q21.size() == 0);
    if (r2 && !e12) void'(q12.pop_front());
    if (w1 && !f12) q12.push_back(d1);
    if (r1 && !e21) void'(q21.pop_front());
    if (w2 && !f21) q21.push_back(d2);
    m_ovf1 = (w1 && f12) ? 1'b1 : (c1 ? 1'b0 : m_ovf1);
    m_ovf2 = (w2 && f21) ? 1'b1 : (c2 ? 1'b0 : m_ovf2);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q12.delete(); q21.delete(); m_ovf1 = 0; m_ovf2 = 0;
  endtask

  initial begin
    resetn = 1'b0;
    we_1 = 0; data_1_in = 0; re_1 = 0; clr_ovf_1 = 0;
    we_2 = 0; data_2_in = 0; re_2 = 0; clr_ovf_2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) resetn = 1'b1;

    // Single word 1->2, then pop
    cyc("push11", 1, 8'h11, 0, 0, 0, 0, 0, 0);
    chk("push11.exp_data", 32'(data_2_out), 32'h11);
    cyc("pop11",  0, 0, 0, 0, 0, 0, 1, 0);
    chk("pop11.gated_zero", 32'(data_2_out), 32'h00);

    // Fill 1->2, overflow, drain in order
    for (int i = 0; i < 4; i++) cyc("fillA", 1, 8'hA0 + 8'(i), 0, 0, 0, 0, 0, 0);
    chk("fillA.wait_1", 32'(wait_1), 32'd1);
    chk("fillA.level_2", 32'(level_2), 32'd4);
    cyc("dropA4", 1, 8'hA4, 0, 0, 0, 0, 0, 0);
    chk("dropA4.ovf_1", 32'(ovf_1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drainA.order", 32'(data_2_out), 32'hA0 + i);
      cyc("drainA", 0, 0, 0, 0, 0, 0, 1, 0);
    end
    cyc("clrA", 0, 0, 0, 1, 0, 0, 0, 0);

    // Push while full with a concurrent pop: pop only, push dropped
    for (int i = 0; i < 4; i++) cyc("fillB", 1, 8'h30 + 8'(i), 0, 0, 0, 0, 0, 0);
    cyc("pushB0_pop", 1, 8'hB0, 0, 0, 0, 0, 1, 0);
    chk("pushB0_pop.level_2", 32'(level_2), 32'd3);
    chk("pushB0_pop.ovf_1", 32'(ovf_1), 32'd1);
    cyc("clr1", 0, 0, 0, 1, 0, 0, 0, 0);
    chk("clr1.ovf_1", 32'(ovf_1), 32'd0);
    cyc("refill", 1, 8'h34, 0, 0, 0, 0, 0, 0);
    cyc("drop_clr", 1, 8'hB1, 0, 1, 0, 0, 0, 0);
    chk("drop_clr.ovf_1", 32'(ovf_1), 32'd1);
    for (int i = 0; i < 4; i++) cyc("drainB", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("clrB", 0, 0, 0, 1, 0, 0, 0, 0);

    // Streaming through the pointer wrap
    cyc("wrap0", 1, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 10; i++) begin
      chk("wrap.order", 32'(data_2_out), 32'(i - 1));
      cyc("wrap", 1, 8'(i), 0, 0, 0, 0, 1, 0);
    end
    chk("wrap.last", 32'(data_2_out), 32'h09);
    cyc("wrapend", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("wrap.no_ovf", 32'(ovf_1), 32'd0);

    // Both directions in the same cycle, then pops on empty FIFOs
    cyc("bidir", 1, 8'h5A, 0, 0, 1, 8'hC3, 0, 0);
    chk("bidir.d2", 32'(data_2_out), 32'h5A);
    chk("bidir.d1", 32'(data_1_out), 32'hC3);
    cyc("bidir_pop", 0, 0, 1, 0, 0, 0, 1, 0);
    cyc("pop_empty", 0, 0, 1, 0, 0, 0, 1, 0);

    // Randomised traffic on both sides
    for (int i = 0; i < 300; i++) begin
      cyc("rand",
          ($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10));
    end
    for (int i = 0; i < 5; i++) cyc("flush", 0, 0, 1, 1, 0, 0, 1, 1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) cyc("burst", 1, 8'hE0 + 8'(i), 0, 0, 1, 8'hD0 + 8'(i), 0, 0);
    we_1 = 0; we_2 = 0;
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all("arst_immediate");
    @(posedge clk);
    #1 check_all("arst_held");
    @(negedge clk) resetn = 1'b1;
    cyc("post_reset", 1, 8'h77, 0, 0, 0, 0, 0, 0);
    chk("post_reset.level_2", 32'(level_2), 32'd1);
    chk("post_reset.data_2", 32'(data_2_out), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nf_mailbox.md
Name: nf_mailbox

Overview:
- Single-clock, bidirectional message mailbox between two masters, side 1 and side 2, e.g. the CPU and a peripheral engine.
- Parametrised successor of the two-register exchange block.
  - Each direction gets a FIFO of configurable width and depth.
  - Adds receive-valid/pop, occupancy, full back-pressure and sticky overflow flags.
- Sits in the periphery tree behind the bus slave decode.

Parameters:
- width, 8, data word width in bits (>=1)
- depth, 4, words per direction FIFO; power of two, >=2

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- we_1  in  1  side 1 push into FIFO 1->2
- data_1_in  in  width  side 1 write data
- re_1  in  1  side 1 pop from FIFO 2->1
- data_1_out  out  width  head word of FIFO 2->1; '0 when rx_valid_1=0
- rx_valid_1  out  1  FIFO 2->1 not empty
- wait_1  out  1  FIFO 1->2 full
- level_1  out  $clog2(depth)+1  words pending in FIFO 2->1
- ovf_1  out  1  sticky: side 1 pushed while wait_1=1
- clr_ovf_1  in  1  clears ovf_1
- we_2, data_2_in, re_2, data_2_out, rx_valid_2, wait_2, level_2, ovf_2, clr_ovf_2: mirror of side 1
  - Side 2 pushes into FIFO 2->1 and pops from FIFO 1->2.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All pointers 0.
  - rx_valid_x=0, wait_x=0, level_x=0, ovf_x=0, data_x_out='0.
  - Storage contents are don't-care.
- Each FIFO holds read and write pointers of $clog2(depth)+1 bits; the MSB is a wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
  - level = wr_ptr - rd_ptr, modulo 2^($clog2(depth)+1).
- All status outputs are combinational from registered pointers. There is no combinational path from we/re to any output.
- Push: we_x=1 and FIFO not full at the clock edge -> word stored at wr index, wr_ptr+1.
  - Visible at the far side next cycle: rx_valid rises and level increments at N+1.
- Push while full: word dropped, pointers unchanged, ovf_x set at the next edge.
  - This holds even if the far side pops in the same cycle. Acceptance is judged on the registered full flag only.
- Pop: re_x=1 and rx_valid_x=1 -> rd_ptr+1.
  - data_x_out is first-word-fall-through. It shows the head whenever rx_valid_x=1 and updates to the next word the cycle after the pop.
- Pop while empty: ignored, no flag, pointers unchanged.
- Same FIFO, simultaneous push and pop:
  - Not full and not empty: both occur, level unchanged.
  - Empty: push only.
  - Full: pop only, push dropped with ovf.
- Pointer wrap: indices wrap modulo depth with the wrap bit toggled. Ordering is preserved across wrap.
- Overflow flag precedence: clr_ovf_x=1 clears ovf_x. If a dropping push occurs in the same cycle as clr_ovf_x, set wins (ovf_x=1).
- The two directions are fully independent: no arbitration and no ordering between FIFO 1->2 and FIFO 2->1.
- Reset asserted mid-transfer: pending words are discarded immediately and all outputs return to reset values asynchronously.
- Parameter checks: elaboration-time assertion that depth is a power of two and >=2, and width>=1.

Decomposition:
- No new typedefs.
- Pointer width localparam ($clog2(depth)+1) computed locally. If the team's shared help package already has a clog2 helper, use it; no new package content is required.
- One natural sub-module: nf_sync_fifo, parametrised by width and depth.
  - Ports: clk, resetn, push, pdata, pop, head, empty, full, level.
  - Instantiated twice.
  - Overflow flags and output gating live in nf_mailbox.

Test Plan (width=8, depth=4):
- Reset, then side 1 pushes 0x11 at cycle N -> rx_valid_2=1, data_2_out=0x11, level_2=1 at N+1. Side 2 pops -> rx_valid_2=0, data_2_out=0x00 the next cycle.
- Side 1 pushes 0xA0..0xA3 back-to-back -> wait_1=1 and level_2=4 after the 4th edge. A 5th push of 0xA4 -> dropped, ovf_1=1. Side 2 drains 0xA0,0xA1,0xA2,0xA3 in order.
- FIFO 1->2 full, side 1 pushes 0xB0 while side 2 pops in the same cycle -> pop accepted, 0xB0 dropped, ovf_1=1, level_2=3. clr_ovf_1 pulse -> ovf_1=0 next cycle. A dropping push coinciding with clr_ovf_1 -> ovf_1 stays 1.
- Wrap: stream 10 words 0x00..0x09 with continuous concurrent push/pop at level 1..2 -> all received in order, no ovf, pointers pass through the wrap.
- Simultaneous bidirectional traffic: side 1 sends 0x5A while side 2 sends 0xC3 in the same cycle -> data_2_out=0x5A and data_1_out=0xC3 next cycle, with no interference. Pop on an empty FIFO -> no state change.
- Assert resetn low for 1 cycle, asynchronously, mid-burst with 3 words pending -> outputs immediately return to reset values. After release, the next push is received first with level=1.
